// File: rtl/alu_resp_monitor.sv
// alu_resp_monitor: compacts ALU responses from an op sweep into a MISR
// signature, checks the alu_sel sweep order and reports pass/fail against a
// golden signature once the last sample of the sweep is accepted.
// Optional macro ALU_MON_LOG_EN adds a 16-entry sample log with a registered
// read port (log_addr / log_data).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset, waiting for start
// COLLECT | sweep in progress, accepting samples on in_valid
// DONE    | sweep complete, done/pass/seq_err/signature held until start
module alu_resp_monitor #(
    parameter int               DATA_W   = 8,
    parameter int               NUM_OPS  = 16,
    parameter int               OP_BASE  = 1,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF,
    parameter logic [SIG_W-1:0] POLY     = 16'h1021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              carry_out,
    input  logic [SIG_W-1:0]  expected_sig,
`ifdef ALU_MON_LOG_EN
    input  logic [3:0]        log_addr,
    output logic [DATA_W:0]   log_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              seq_err,
    output logic [SIG_W-1:0]  signature,
    output logic [4:0]        sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(NUM_OPS - 1);
    localparam logic [3:0] OP_BASE4 = 4'(OP_BASE);

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               seq_err_q, seq_err_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [4:0]         cnt_q, cnt_d;

    logic               accept;
    logic [3:0]         exp_op;
    logic [SIG_W-1:0]   sample;
    logic [SIG_W-1:0]   sig_next;

    // Sample acceptance, expected op and the MISR step for the current sample
    always_comb begin
        accept   = (state_q == S_COLLECT) && in_valid;
        exp_op   = OP_BASE4 + cnt_q[3:0];
        sample   = SIG_W'({carry_out, alu_out});
        sig_next = ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)) ^ sample;
    end

    // Next-state and next-output computation for the sweep FSM
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        pass_d    = pass_q;
        seq_err_d = seq_err_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // a sample arriving together with start is discarded
                if (start) begin
                    state_d   = S_COLLECT;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    seq_err_d = 1'b0;
                    sig_d     = SIG_SEED;
                    cnt_d     = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    sig_d     = sig_next;
                    cnt_d     = cnt_q + 5'd1;
                    seq_err_d = seq_err_q | (alu_sel != exp_op);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (sig_next == expected_sig) && !seq_err_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register the FSM and its outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            seq_err_q <= 1'b0;
            sig_q     <= SIG_SEED;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            seq_err_q <= seq_err_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy       = (state_q == S_COLLECT);
    assign done       = done_q;
    assign pass       = pass_q;
    assign seq_err    = seq_err_q;
    assign signature  = sig_q;
    assign sample_cnt = cnt_q;

`ifdef ALU_MON_LOG_EN
    logic [DATA_W:0] log_mem [16];
    logic [DATA_W:0] log_data_q;

    // Sample log write on accept and registered read; contents survive rst
    always_ff @(posedge clk) begin
        if (accept) begin
            log_mem[cnt_q[3:0]] <= {carry_out, alu_out};
        end
        log_data_q <= log_mem[log_addr];
    end

    assign log_data = log_data_q;
`endif

endmodule

// File: tb/tb_alu_resp_monitor.sv
// Self-checking bench for alu_resp_monitor (default parameters).
module tb_alu_resp_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  alu_sel = 4'd0;
    logic [7:0]  alu_out = 8'd0;
    logic        carry_out = 1'b0;
    logic [15:0] expected_sig = 16'd0;
    logic        busy, done, pass, seq_err;
    logic [15:0] signature;
    logic [4:0]  sample_cnt;
`ifdef ALU_MON_LOG_EN
    logic [3:0]  log_addr = 4'd0;
    logic [8:0]  log_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_sig[$];
    logic [4:0]  sb_cnt[$];

    localparam logic [7:0] OPA = 8'h0A;
    localparam logic [7:0] OPB = 8'h02;

    always #5 clk = ~clk;

    alu_resp_monitor dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .alu_sel(alu_sel), .alu_out(alu_out), .carry_out(carry_out),
        .expected_sig(expected_sig),
`ifdef ALU_MON_LOG_EN
        .log_addr(log_addr), .log_data(log_data),
`endif
        .busy(busy), .done(done), .pass(pass), .seq_err(seq_err),
        .signature(signature), .sample_cnt(sample_cnt)
    );

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [8:0] smp);
        return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {7'b0, smp};
    endfunction

    // reference ALU used only to generate stimulus: {carry, result}
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            4'd0:  r = {1'b0, a} + {1'b0, b};
            4'd1:  r = {1'b0, a - b};
            4'd2:  r = {1'b0, a * b};
            4'd3:  r = {1'b0, a / b};
            4'd4:  r = {1'b0, a << 1};
            4'd5:  r = {1'b0, a >> 1};
            4'd6:  r = {1'b0, a[6:0], a[7]};
            4'd7:  r = {1'b0, a[0], a[7:1]};
            4'd8:  r = {1'b0, a & b};
            4'd9:  r = {1'b0, a | b};
            4'd10: r = {1'b0, a ^ b};
            4'd11: r = {1'b0, ~(a | b)};
            4'd12: r = {1'b0, ~(a & b)};
            4'd13: r = {1'b0, ~(a ^ b)};
            4'd14: r = {1'b0, 7'd0, (a > b)};
            default: r = {1'b0, 7'd0, (a == b)};
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || seq_err !== 1'b0 ||
            sample_cnt !== 5'd0 || signature !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b seq_err=%b cnt=%0d sig=%h, want 0 0 0 0 0 ffff",
                     busy, done, pass, seq_err, sample_cnt, signature);
        end
        // reset in the middle of a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            alu_sel  = 4'(n + 1);
            {carry_out, alu_out} = alu_model(alu_sel, OPA, OPB);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (sample_cnt !== 5'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_cnt: cnt=%0d busy=%b, want 5 1", sample_cnt, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sample_cnt !== 5'd0 || signature !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_mid_sweep: busy=%b done=%b cnt=%0d sig=%h, want 0 0 0 ffff",
                     busy, done, sample_cnt, signature);
        end
    endtask

    task automatic test_single_sample();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid  = 1'b1;
        alu_sel   = 4'd1;
        alu_out   = 8'h0C;
        carry_out = 1'b0;
        sb_sig.push_back(16'hEFD3);
        sb_cnt.push_back(5'd1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (signature !== sb_sig.pop_front() || sample_cnt !== sb_cnt.pop_front() ||
            seq_err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL first_sample: sig=%h cnt=%0d seq_err=%b done=%b, want efd3 1 0 0",
                     signature, sample_cnt, seq_err, done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_full_sweep(input bit swap, input bit golden_ok);
        logic [15:0] msig;
        logic [3:0]  op;
        logic [8:0]  smp;
        logic [8:0]  third;
        logic [15:0] got_sig;
        logic [4:0]  got_cnt;
        msig  = 16'hFFFF;
        third = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || signature !== 16'hFFFF || sample_cnt !== 5'd0 ||
            seq_err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_start: busy=%b sig=%h cnt=%0d seq_err=%b done=%b, want 1 ffff 0 0 0",
                     busy, signature, sample_cnt, seq_err, done);
        end
        for (int n = 0; n < 16; n++) begin
            op = 4'(n + 1);
            if (swap && op == 4'd3) op = 4'd4;
            else if (swap && op == 4'd4) op = 4'd3;
            smp  = alu_model(op, OPA, OPB);
            if (n == 2) third = smp;
            msig = misr(msig, smp);
            if (n == 15) expected_sig = golden_ok ? msig : (msig ^ 16'h0001);
            sb_sig.push_back(msig);
            sb_cnt.push_back(5'(n + 1));
            in_valid = 1'b1;
            alu_sel  = op;
            {carry_out, alu_out} = smp;
            tick();
            in_valid = 1'b0;
            got_sig = sb_sig.pop_front();
            got_cnt = sb_cnt.pop_front();
            checks++;
            if (signature !== got_sig || sample_cnt !== got_cnt) begin
                errors++;
                $display("FAIL sweep_sample_%0d: sig=%h cnt=%0d, want %h %0d",
                         n, signature, sample_cnt, got_sig, got_cnt);
            end
            if (n < 15) begin
                // gap cycle; a start pulse mid-sweep must be ignored
                start = (n == 7);
                tick();
                start = 1'b0;
                checks++;
                if (signature !== msig || sample_cnt !== 5'(n + 1) || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_gap_%0d: sig=%h cnt=%0d busy=%b done=%b, want %h %0d 1 0",
                             n, signature, sample_cnt, busy, done, msig, n + 1);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 5'd16 ||
            pass !== (golden_ok && !swap) || seq_err !== swap) begin
            errors++;
            $display("FAIL sweep_end: done=%b busy=%b cnt=%0d pass=%b seq_err=%b, want 1 0 16 %b %b",
                     done, busy, sample_cnt, pass, seq_err, golden_ok && !swap, swap);
        end
`ifdef ALU_MON_LOG_EN
        log_addr = 4'd2;
        tick();
        tick();
        checks++;
        if (log_data !== third) begin
            errors++;
            $display("FAIL log_read: got=%h want=%h", log_data, third);
        end
`else
        if (third === 9'h1FF) $display("note: unexpected third sample");
`endif
    endtask

    task automatic test_ignored();
        logic [15:0] held_sig;
        logic        held_pass;
        held_sig  = signature;
        held_pass = pass;
        in_valid = 1'b1;
        alu_sel  = 4'd1;
        alu_out  = 8'h55;
        tick();
        in_valid = 1'b0;
        checks++;
        if (signature !== held_sig || sample_cnt !== 5'd16 || done !== 1'b1 || pass !== held_pass) begin
            errors++;
            $display("FAIL valid_in_done: sig=%h cnt=%0d done=%b pass=%b, want %h 16 1 %b",
                     signature, sample_cnt, done, pass, held_sig, held_pass);
        end
        // start together with a sample: sample discarded
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || sample_cnt !== 5'd0 || signature !== 16'hFFFF || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL start_with_valid: busy=%b cnt=%0d sig=%h done=%b pass=%b, want 1 0 ffff 0 0",
                     busy, sample_cnt, signature, done, pass);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_cnt !== 5'd0 || signature !== 16'hFFFF) begin
            errors++;
            $display("FAIL valid_in_idle: busy=%b cnt=%0d sig=%h, want 0 0 ffff", busy, sample_cnt, signature);
        end
    endtask

    task automatic test_restart_clears();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (seq_err !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: seq_err=%b done=%b pass=%b busy=%b, want 0 0 0 1",
                     seq_err, done, pass, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_full_sweep(1'b0, 1'b1);
        test_ignored();
        test_full_sweep(1'b0, 1'b0);
        test_full_sweep(1'b1, 1'b1);
        test_restart_clears();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
